div_seq_ctrl: RTL and testbench

//  Sequencer between the RV32M execute stage and the 32-bit unsigned restoring divider.

---
 rtl/div_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencer between the RV32M execute stage and a 32-bit unsigned restoring divider.
// Resolves special cases in one cycle, sign-corrects divider results and keeps a one-entry result cache.
module div_seq_ctrl #(
    parameter int CACHE_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_div_start,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    input  logic        i_div_busy,
    input  logic [31:0] i_div_q,
    input  logic [31:0] i_div_r
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_FIX   = 3'd3,
        S_RESP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_op_rem;
    logic        r_sgn;
    logic        r_seen_busy;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [31:0] r_q_raw;
    logic [31:0] r_r_raw;
    logic [31:0] r_rsp_data;

    logic        r_cache_valid;
    logic        r_cache_sgn;
    logic [31:0] r_cache_a;
    logic [31:0] r_cache_b;
    logic [31:0] r_cache_q;
    logic [31:0] r_cache_r;

    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_small;
    logic        w_hit;
    logic        w_direct;
    logic        w_accept;
    logic [31:0] w_dir_q;
    logic [31:0] w_dir_r;
    logic [31:0] w_dir_data;
    logic        w_div_done;
    logic        w_fix_qneg;
    logic        w_fix_rneg;
    logic [31:0] w_fix_q;
    logic [31:0] w_fix_r;

    // Request decode: magnitudes wrap, so the magnitude of 0x80000000 is itself.
    assign w_sgn    = ~i_req_op[0];
    assign w_a_neg  = w_sgn & i_req_a[31];
    assign w_b_neg  = w_sgn & i_req_b[31];
    assign w_ua     = w_a_neg ? (~i_req_a + 32'd1) : i_req_a;
    assign w_ub     = w_b_neg ? (~i_req_b + 32'd1) : i_req_b;
    assign w_b_zero = (i_req_b == 32'd0);
    assign w_ovf    = w_sgn & (i_req_a == 32'h8000_0000) & (i_req_b == 32'hFFFF_FFFF);
    assign w_small  = (w_ua < w_ub);
    assign w_hit    = (CACHE_EN != 0) & r_cache_valid & (r_cache_a == i_req_a)
                    & (r_cache_b == i_req_b) & (r_cache_sgn == w_sgn);
    assign w_direct = w_b_zero | w_ovf | w_small | w_hit;
    assign w_accept = (r_state == S_IDLE) & i_req_valid & ~i_flush;

    always_comb begin
        w_dir_q = 32'd0;
        w_dir_r = 32'd0;
        if (w_b_zero) begin
            w_dir_q = 32'hFFFF_FFFF;
            w_dir_r = i_req_a;
        end else if (w_ovf) begin
            w_dir_q = 32'h8000_0000;
            w_dir_r = 32'd0;
        end else if (w_small) begin
            w_dir_q = 32'd0;
            w_dir_r = w_a_neg ? (~w_ua + 32'd1) : w_ua;
        end else if (w_hit) begin
            w_dir_q = r_cache_q;
            w_dir_r = r_cache_r;
        end
    end

    assign w_dir_data = i_req_op[1] ? w_dir_r : w_dir_q;

    assign w_div_done = r_seen_busy & ~i_div_busy;
    assign w_fix_qneg = r_sgn & (r_a[31] ^ r_b[31]);
    assign w_fix_rneg = r_sgn & r_a[31];
    assign w_fix_q    = w_fix_qneg ? (~r_q_raw + 32'd1) : r_q_raw;
    assign w_fix_r    = w_fix_rneg ? (~r_r_raw + 32'd1) : r_r_raw;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_div_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = w_direct ? S_RESP : S_START;
                end
            end
            S_START: begin
                o_div_start  = 1'b1;
                w_next_state = i_flush ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (i_flush) begin
                    w_next_state = S_DRAIN;
                end else if (w_div_done) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = i_flush ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_flush || i_rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_div_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Divider operands are written only at acceptance, so they stay put through START/RUN/DRAIN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op_rem    <= 1'b0;
            r_sgn       <= 1'b0;
            r_seen_busy <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_div_a     <= 32'd0;
            r_div_b     <= 32'd0;
            r_q_raw     <= 32'd0;
            r_r_raw     <= 32'd0;
            r_rsp_data  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_rem <= i_req_op[1];
                        r_sgn    <= w_sgn;
                        r_a      <= i_req_a;
                        r_b      <= i_req_b;
                        if (w_direct) begin
                            r_rsp_data <= w_dir_data;
                        end else begin
                            r_div_a     <= w_ua;
                            r_div_b     <= w_ub;
                            r_seen_busy <= 1'b0;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (i_div_busy) begin
                        r_seen_busy <= 1'b1;
                    end
                    if ((r_state == S_RUN) && w_div_done) begin
                        r_q_raw <= i_div_q;
                        r_r_raw <= i_div_r;
                    end
                end
                S_FIX: begin
                    if (!i_flush) begin
                        r_rsp_data <= r_op_rem ? w_fix_r : w_fix_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The tag ignores op[1] so a DIV and a REM on the same operands share one entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cache_valid <= 1'b0;
            r_cache_sgn   <= 1'b0;
            r_cache_a     <= 32'd0;
            r_cache_b     <= 32'd0;
            r_cache_q     <= 32'd0;
            r_cache_r     <= 32'd0;
        end else if (i_flush) begin
            r_cache_valid <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_cache_valid <= (CACHE_EN != 0);
            r_cache_sgn   <= r_sgn;
            r_cache_a     <= r_a;
            r_cache_b     <= r_b;
            r_cache_q     <= w_fix_q;
            r_cache_r     <= w_fix_r;
        end
    end

    assign o_rsp_data = r_rsp_data;
    assign o_div_a    = r_div_a;
    assign o_div_b    = r_div_b;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed testbench for div_seq_ctrl with a small multi-cycle divider model attached.
module tb_div_seq_ctrl;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        reqValid;
    logic        reqReady;
    logic [1:0]  reqOp;
    logic [31:0] reqA;
    logic [31:0] reqB;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        divStart;
    logic [31:0] divA;
    logic [31:0] divB;
    logic        divBusy;
    logic [31:0] divQ;
    logic [31:0] divR;

    int vectorCount = 0;
    int missCount   = 0;
    int startCount  = 0;
    int divCnt;

    div_seq_ctrl #(.CACHE_EN(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_op    (reqOp),
        .i_req_a     (reqA),
        .i_req_b     (reqB),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_data  (rspData),
        .o_div_start (divStart),
        .o_div_a     (divA),
        .o_div_b     (divB),
        .i_div_busy  (divBusy),
        .i_div_q     (divQ),
        .i_div_r     (divR)
    );

    always #5 clk = ~clk;

    // Divider model: busy for four cycles after the start pulse, results only final when busy falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            divBusy <= 1'b0;
            divCnt  <= 0;
            divQ    <= 32'd0;
            divR    <= 32'd0;
        end else if (divStart) begin
            divBusy <= 1'b1;
            divCnt  <= 4;
            divQ    <= 32'hDEAD_BEEF;
            divR    <= 32'hDEAD_BEEF;
        end else if (divBusy) begin
            if (divCnt == 1) begin
                divBusy <= 1'b0;
                divQ    <= (divB == 32'd0) ? 32'hFFFF_FFFF : divA / divB;
                divR    <= (divB == 32'd0) ? divA : divA % divB;
            end
            divCnt <= divCnt - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && divStart) begin
            startCount <= startCount + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic sendRequest(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        reqOp    = op;
        reqA     = a;
        reqB     = b;
        reqValid = 1'b1;
        while (!reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reqReady", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
    endtask

    task automatic waitResponse(output logic [31:0] data, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspValid && lat < 100);
        data = rspData;
    endtask

    task automatic finishHandshake();
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expData,
                                 input int expLat, input int expStarts);
        int          s0;
        int          lat;
        logic [31:0] d;
        s0 = startCount;
        sendRequest(op, a, b);
        waitResponse(d, lat);
        checkOutput({tag, ".data"}, d, expData);
        checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".starts"}, 32'(startCount - s0), 32'(expStarts));
        finishHandshake();
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          s0;
        bit          sawValid;

        rst      = 1'b1;
        flush    = 1'b0;
        reqValid = 1'b0;
        rspReady = 1'b0;
        reqOp    = 2'b00;
        reqA     = 32'd0;
        reqB     = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset.divStart", {31'd0, divStart}, 32'd0);
        checkOutput("reset.divA", divA, 32'd0);
        checkOutput("reset.divB", divB, 32'd0);
        checkOutput("reset.rspData", rspData, 32'd0);
        checkOutput("reset.reqReady", {31'd0, reqReady}, 32'd1);
        rst = 1'b0;

        // Divider path, then a cache hit on the partner op; latency 8 counts negedges after accept.
        applyStimulus("divu100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 8, 1);
        applyStimulus("remu100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1, 0);
        applyStimulus("div-7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 8, 1);
        applyStimulus("rem-7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0);
        applyStimulus("div7_-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 8, 1);

        applyStimulus("div5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        applyStimulus("rem5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
        applyStimulus("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        applyStimulus("remOvf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        applyStimulus("divuNoOvf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        applyStimulus("divu3_9", OP_DIVU, 32'd3, 32'd9, 32'd0, 1, 0);
        applyStimulus("remu3_9", OP_REMU, 32'd3, 32'd9, 32'd3, 1, 0);
        applyStimulus("rem-3_9", OP_REM, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, 1, 0);

        // Response held while the consumer stalls; a pending request must wait.
        s0 = startCount;
        sendRequest(OP_DIVU, 32'd50, 32'd5);
        waitResponse(d, lat);
        checkOutput("hold.lat", 32'(lat), 32'd8);
        reqOp    = OP_REMU;
        reqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold.rspValid", {31'd0, rspValid}, 32'd1);
            checkOutput("hold.rspData", rspData, 32'd10);
            checkOutput("hold.reqReady", {31'd0, reqReady}, 32'd0);
        end
        finishHandshake();
        checkOutput("hold.starts", 32'(startCount - s0), 32'd1);
        sendRequest(OP_REMU, 32'd50, 32'd5);
        waitResponse(d, lat);
        checkOutput("hold.next.data", d, 32'd0);
        checkOutput("hold.next.lat", 32'(lat), 32'd1);
        finishHandshake();

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        reqOp    = OP_REMU;
        reqA     = 32'd3;
        reqB     = 32'd9;
        reqValid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        reqValid = 1'b0;
        @(negedge clk);
        checkOutput("idleFlush.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("idleFlush.reqReady", {31'd0, reqReady}, 32'd1);

        // Flush during RUN drains the divider and invalidates the cache.
        applyStimulus("divu1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd333, 8, 1);
        s0 = startCount;
        sendRequest(OP_DIVU, 32'd999, 32'd7);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("drain.reqReady", {31'd0, reqReady}, 32'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rspValid) sawValid = 1'b1;
        end
        checkOutput("drain.noRsp", {31'd0, sawValid}, 32'd0);
        checkOutput("drain.idle", {31'd0, reqReady}, 32'd1);
        checkOutput("drain.starts", 32'(startCount - s0), 32'd1);
        applyStimulus("remu1000_3", OP_REMU, 32'd1000, 32'd3, 32'd1, 8, 1);

        // Reset mid-RUN returns to IDLE immediately.
        sendRequest(OP_DIVU, 32'd1000, 32'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstRun.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("rstRun.divStart", {31'd0, divStart}, 32'd0);
        checkOutput("rstRun.reqReady", {31'd0, reqReady}, 32'd1);
        checkOutput("rstRun.divA", divA, 32'd0);
        rst = 1'b0;
        applyStimulus("divu1000_7", OP_DIVU, 32'd1000, 32'd7, 32'd142, 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
